// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug command path: IR codes and the
// command entry layout at the default IR/scan widths.
package nios2_dbg_pkg;

    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    localparam int DEF_IR_WIDTH = 2;
    localparam int DEF_SR_WIDTH = 38;

    typedef struct packed {
        logic                    is_ir;
        logic [DEF_IR_WIDTH-1:0] ir;
        logic [DEF_SR_WIDTH-1:0] data;
    } cmd_entry_t;

endpackage

// File: rtl/nios2_jtag_debug_cmd_queue_if.sv
// Command handshake between the debug command queue (master) and the OCI
// debug logic (slave).
interface nios2_jtag_debug_cmd_queue_if #(
    parameter int IR_WIDTH = 2,
    parameter int SR_WIDTH = 38
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_is_ir;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [SR_WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, cmd_is_ir, cmd_ir, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_is_ir, cmd_ir, cmd_data, output cmd_ready);
endinterface

// File: rtl/nios2_dbg_sync_fifo.sv
// Generic first-word-fall-through FIFO; head reads 0 while empty, and a push
// into a full FIFO is accepted only when a pop happens in the same cycle.
module nios2_dbg_sync_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left unreset; empty forces the head to 0, so stale words never leak.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/nios2_jtag_debug_cmd_queue.sv
// System-clock side of the JTAG debug path: synchronises the TCK update strobes,
// turns each rising edge into a command and queues it for the OCI logic.
module nios2_jtag_debug_cmd_queue
    import nios2_dbg_pkg::*;
#(
    parameter int IR_WIDTH    = 2,
    parameter int SR_WIDTH    = 38,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic [IR_WIDTH-1:0]           ir_in,
    input  logic [SR_WIDTH-1:0]           sr,
    nios2_jtag_debug_cmd_queue_if.master  cmd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr
);
    typedef struct packed {
        logic                is_ir;
        logic [IR_WIDTH-1:0] ir;
        logic [SR_WIDTH-1:0] data;
    } cmd_t;

    logic [SYNC_STAGES-1:0] udr_sync, uir_sync, fill;
    logic udr_prev, uir_prev, udr_armed, uir_armed;
    logic udr_last, uir_last, udr_ev, uir_ev;
    logic push, pop, drop, full, empty;
    cmd_t push_entry, head;

    assign udr_last = udr_sync[SYNC_STAGES-1];
    assign uir_last = uir_sync[SYNC_STAGES-1];

    // A strobe arms only after the chain has filled and shown it low, so a level
    // held through reset cannot masquerade as a fresh edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync  <= '0;
            uir_sync  <= '0;
            fill      <= '0;
            udr_prev  <= 1'b0;
            uir_prev  <= 1'b0;
            udr_armed <= 1'b0;
            uir_armed <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            udr_prev <= udr_last;
            uir_prev <= uir_last;
            if (fill[SYNC_STAGES-1] && !udr_last) udr_armed <= 1'b1;
            if (fill[SYNC_STAGES-1] && !uir_last) uir_armed <= 1'b1;
        end
    end

    assign udr_ev = udr_last && !udr_prev && udr_armed;
    assign uir_ev = uir_last && !uir_prev && uir_armed;

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        push_entry = '0;
        if (udr_ev) begin
            push_entry.ir   = ir_in;
            push_entry.data = sr;
        end else if (uir_ev) begin
            push_entry.is_ir = 1'b1;
            push_entry.ir    = ir_in;
        end
    end

    assign push = udr_ev || uir_ev;
    assign pop  = !empty && cmd.cmd_ready;
    assign drop = (udr_ev && uir_ev) || (push && full && !pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

    nios2_dbg_sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign cmd.cmd_valid = !empty;
    assign cmd.cmd_is_ir = head.is_ir;
    assign cmd.cmd_ir    = head.ir;
    assign cmd.cmd_data  = head.data;

endmodule

// File: tb/tb_nios2_jtag_debug_cmd_queue.sv
// Self-checking bench for nios2_jtag_debug_cmd_queue against a queue-based model.
module tb_nios2_jtag_debug_cmd_queue;
    import nios2_dbg_pkg::*;

    localparam int IRW   = DEF_IR_WIDTH;
    localparam int SRW   = DEF_SR_WIDTH;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           vs_udr = 1'b0;
    logic           vs_uir = 1'b0;
    logic           overflow_clr = 1'b0;
    logic [IRW-1:0] ir_in = '0;
    logic [SRW-1:0] sr = '0;
    logic [LW-1:0]  fifo_level;
    logic           overflow;

    nios2_jtag_debug_cmd_queue_if #(.IR_WIDTH(IRW), .SR_WIDTH(SRW)) cmd_if ();

    nios2_jtag_debug_cmd_queue #(
        .IR_WIDTH(IRW), .SR_WIDTH(SRW), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vs_udr       (vs_udr),
        .vs_uir       (vs_uir),
        .ir_in        (ir_in),
        .sr           (sr),
        .cmd          (cmd_if),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int             land;
        logic           is_ir;
        logic [IRW-1:0] ir;
        logic [SRW-1:0] data;
    } pend_t;

    cmd_entry_t model_q[$];
    pend_t      pend_q[$];
    bit         model_ovf;
    int         cycle;
    int         checks;
    int         failures;

    function automatic cmd_entry_t model_head();
        cmd_entry_t h;
        h = '0;
        if (model_q.size() > 0) h = model_q[0];
        return h;
    endfunction

    task automatic model_reset();
        model_q.delete();
        pend_q.delete();
        model_ovf = 1'b0;
    endtask

    // Raise strobes now; the entry is due at the (SYNC+1)-th following edge.
    task automatic raise(input bit dr, input bit ir_ev, input logic [IRW-1:0] irv,
                         input logic [SRW-1:0] srv);
        pend_t p;
        ir_in = irv;
        sr    = srv;
        if (dr) begin
            vs_udr = 1'b1;
            p = '{land: cycle + SYNC + 1, is_ir: 1'b0, ir: irv, data: srv};
            pend_q.push_back(p);
        end
        if (ir_ev) begin
            vs_uir = 1'b1;
            p = '{land: cycle + SYNC + 1, is_ir: 1'b1, ir: irv, data: '0};
            pend_q.push_back(p);
        end
    endtask

    // One clock: apply ready/clr, advance the model by the queue rules, then
    // return at the following falling edge.
    task automatic step(input bit ready, input bit clr);
        cmd_entry_t e_dr, e_ir, e;
        bit has_dr, has_ir, pop, push, drop;
        cmd_if.cmd_ready = ready;
        overflow_clr     = clr;
        has_dr = 1'b0; has_ir = 1'b0; push = 1'b0; drop = 1'b0;
        e_dr = '0; e_ir = '0; e = '0;
        pop = (model_q.size() > 0) && ready;
        foreach (pend_q[i]) begin
            if (pend_q[i].land == cycle + 1) begin
                if (pend_q[i].is_ir) begin
                    has_ir = 1'b1;
                    e_ir = '{is_ir: 1'b1, ir: pend_q[i].ir, data: pend_q[i].data};
                end else begin
                    has_dr = 1'b1;
                    e_dr = '{is_ir: 1'b0, ir: pend_q[i].ir, data: pend_q[i].data};
                end
            end
        end
        if (has_dr && has_ir) drop = 1'b1;
        if (has_dr)      begin e = e_dr; push = 1'b1; end
        else if (has_ir) begin e = e_ir; push = 1'b1; end
        if (push && model_q.size() == DEPTH && !pop) begin
            push = 1'b0;
            drop = 1'b1;
        end
        if (pop)  void'(model_q.pop_front());
        if (push) model_q.push_back(e);
        if (drop)     model_ovf = 1'b1;
        else if (clr) model_ovf = 1'b0;
        @(posedge clk);
        cycle++;
        for (int i = pend_q.size() - 1; i >= 0; i--)
            if (pend_q[i].land <= cycle) pend_q.delete(i);
        @(negedge clk);
    endtask

    task automatic event_seq(input bit dr, input bit ir_ev, input logic [IRW-1:0] irv,
                             input logic [SRW-1:0] srv, input bit ready);
        raise(dr, ir_ev, irv, srv);
        repeat (3) step(ready, 1'b0);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        repeat (3) step(ready, 1'b0);
    endtask

    task automatic test_reset();
        #7;
        reset = 1'b1;
        #1;
        checks += 6;
        if (cmd_if.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", cmd_if.cmd_valid); end
        if (cmd_if.cmd_is_ir !== 1'b0) begin failures++; $display("FAIL reset_is_ir: got %b expected 0", cmd_if.cmd_is_ir); end
        if (cmd_if.cmd_ir !== '0) begin failures++; $display("FAIL reset_ir: got %h expected 0", cmd_if.cmd_ir); end
        if (cmd_if.cmd_data !== '0) begin failures++; $display("FAIL reset_data: got %h expected 0", cmd_if.cmd_data); end
        if (fifo_level !== '0) begin failures++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (4) step(1'b0, 1'b0);
    endtask

    task automatic test_single_dr();
        raise(1'b1, 1'b0, IR_BREAK, 38'h2A_DEAD_BEEF);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (cmd_if.cmd_valid !== 1'b0) begin failures++; $display("FAIL dr_early_valid: got %b expected 0 after edge 2", cmd_if.cmd_valid); end
        step(1'b0, 1'b0);
        checks += 5;
        if (cmd_if.cmd_valid !== 1'b1) begin failures++; $display("FAIL dr_valid: got %b expected 1 after edge 3", cmd_if.cmd_valid); end
        if (cmd_if.cmd_data !== 38'h2A_DEAD_BEEF) begin failures++; $display("FAIL dr_data: got %h expected 2adeadbeef", cmd_if.cmd_data); end
        if (cmd_if.cmd_ir !== IR_BREAK) begin failures++; $display("FAIL dr_ir: got %b expected 10", cmd_if.cmd_ir); end
        if (cmd_if.cmd_is_ir !== 1'b0) begin failures++; $display("FAIL dr_is_ir: got %b expected 0", cmd_if.cmd_is_ir); end
        if (fifo_level !== LW'(1)) begin failures++; $display("FAIL dr_level: got %0d expected 1", fifo_level); end
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (fifo_level !== LW'(1)) begin failures++; $display("FAIL dr_held_level: got %0d expected 1", fifo_level); end
        vs_udr = 1'b0;
        step(1'b1, 1'b0);
        checks += 3;
        if (fifo_level !== '0) begin failures++; $display("FAIL dr_pop_level: got %0d expected 0", fifo_level); end
        if (cmd_if.cmd_valid !== 1'b0) begin failures++; $display("FAIL dr_pop_valid: got %b expected 0", cmd_if.cmd_valid); end
        if (cmd_if.cmd_data !== '0) begin failures++; $display("FAIL dr_empty_data: got %h expected 0", cmd_if.cmd_data); end
        repeat (3) step(1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int k = 1; k <= 5; k++) event_seq(1'b1, 1'b0, IR_OCIMEM, SRW'(k), 1'b0);
        checks += 2;
        if (fifo_level !== LW'(DEPTH)) begin failures++; $display("FAIL bp_level: got %0d expected %0d", fifo_level, DEPTH); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        for (int k = 1; k <= 4; k++) begin
            checks += 2;
            if (cmd_if.cmd_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid: got %b expected 1 at entry %0d", cmd_if.cmd_valid, k); end
            if (cmd_if.cmd_data !== SRW'(k)) begin failures++; $display("FAIL bp_drain_data: got %0h expected %0h", cmd_if.cmd_data, k); end
            step(1'b1, 1'b0);
        end
        checks += 2;
        if (fifo_level !== '0) begin failures++; $display("FAIL bp_drained_level: got %0d expected 0", fifo_level); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL bp_sticky: got %b expected 1", overflow); end
        step(1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL bp_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int k = 11; k <= 14; k++) event_seq(1'b1, 1'b0, IR_TRACECTRL, SRW'(k), 1'b0);
        raise(1'b1, 1'b0, IR_TRACECTRL, SRW'(15));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        checks += 3;
        if (fifo_level !== LW'(DEPTH)) begin failures++; $display("FAIL fpp_level: got %0d expected %0d", fifo_level, DEPTH); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_overflow: got %b expected 0", overflow); end
        if (cmd_if.cmd_data !== SRW'(12)) begin failures++; $display("FAIL fpp_head: got %0h expected c", cmd_if.cmd_data); end
        vs_udr = 1'b0;
        for (int k = 12; k <= 15; k++) begin
            checks++;
            if (cmd_if.cmd_data !== SRW'(k)) begin failures++; $display("FAIL fpp_order: got %0h expected %0h", cmd_if.cmd_data, k); end
            step(1'b1, 1'b0);
        end
        checks++;
        if (fifo_level !== '0) begin failures++; $display("FAIL fpp_drained: got %0d expected 0", fifo_level); end
        repeat (2) step(1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        event_seq(1'b1, 1'b1, IR_TRACEMEM, 38'h15, 1'b0);
        checks += 5;
        if (fifo_level !== LW'(1)) begin failures++; $display("FAIL sim_level: got %0d expected 1", fifo_level); end
        if (cmd_if.cmd_is_ir !== 1'b0) begin failures++; $display("FAIL sim_is_ir: got %b expected 0", cmd_if.cmd_is_ir); end
        if (cmd_if.cmd_ir !== IR_TRACEMEM) begin failures++; $display("FAIL sim_ir: got %b expected 01", cmd_if.cmd_ir); end
        if (cmd_if.cmd_data !== 38'h15) begin failures++; $display("FAIL sim_data: got %h expected 15", cmd_if.cmd_data); end
        if (overflow !== 1'b1) begin failures++; $display("FAIL sim_overflow: got %b expected 1", overflow); end
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
    endtask

    task automatic test_random();
        cmd_entry_t h;
        int hold, low;
        bit is_dr;
        for (int n = 0; n < 24; n++) begin
            is_dr = ($urandom_range(0, 9) < 6);
            hold  = $urandom_range(2, 4);
            low   = $urandom_range(2, 4);
            raise(is_dr, !is_dr, IRW'($urandom), {6'($urandom), 32'($urandom)});
            for (int s = 0; s < hold + low; s++) begin
                if (s == hold) begin vs_udr = 1'b0; vs_uir = 1'b0; end
                step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
                h = model_head();
                checks += 6;
                if (cmd_if.cmd_valid !== (model_q.size() > 0)) begin failures++; $display("FAIL rnd_valid: got %b expected %b", cmd_if.cmd_valid, model_q.size() > 0); end
                if (cmd_if.cmd_is_ir !== h.is_ir) begin failures++; $display("FAIL rnd_is_ir: got %b expected %b", cmd_if.cmd_is_ir, h.is_ir); end
                if (cmd_if.cmd_ir !== h.ir) begin failures++; $display("FAIL rnd_ir: got %b expected %b", cmd_if.cmd_ir, h.ir); end
                if (cmd_if.cmd_data !== h.data) begin failures++; $display("FAIL rnd_data: got %h expected %h", cmd_if.cmd_data, h.data); end
                if (fifo_level !== LW'(model_q.size())) begin failures++; $display("FAIL rnd_level: got %0d expected %0d", fifo_level, model_q.size()); end
                if (overflow !== model_ovf) begin failures++; $display("FAIL rnd_overflow: got %b expected %b", overflow, model_ovf); end
            end
        end
        while (model_q.size() > 0) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        checks += 2;
        if (fifo_level !== '0) begin failures++; $display("FAIL rnd_final_level: got %0d expected 0", fifo_level); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL rnd_final_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_reset_mid_queue();
        for (int k = 21; k <= 23; k++) event_seq(1'b1, 1'b0, IR_BREAK, SRW'(k), 1'b0);
        checks++;
        if (fifo_level !== LW'(3)) begin failures++; $display("FAIL rmq_prelevel: got %0d expected 3", fifo_level); end
        vs_udr = 1'b1;
        sr = SRW'(24);
        step(1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks += 3;
        if (fifo_level !== '0) begin failures++; $display("FAIL rmq_level: got %0d expected 0", fifo_level); end
        if (cmd_if.cmd_valid !== 1'b0) begin failures++; $display("FAIL rmq_valid: got %b expected 0", cmd_if.cmd_valid); end
        if (cmd_if.cmd_data !== '0) begin failures++; $display("FAIL rmq_data: got %h expected 0", cmd_if.cmd_data); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) step(1'b0, 1'b0);
        checks += 2;
        if (fifo_level !== '0) begin failures++; $display("FAIL rmq_held_level: got %0d expected 0", fifo_level); end
        if (cmd_if.cmd_valid !== 1'b0) begin failures++; $display("FAIL rmq_held_valid: got %b expected 0", cmd_if.cmd_valid); end
        vs_udr = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        event_seq(1'b1, 1'b0, IR_OCIMEM, 38'h33, 1'b0);
        checks += 2;
        if (fifo_level !== LW'(1)) begin failures++; $display("FAIL rmq_rearm_level: got %0d expected 1", fifo_level); end
        if (cmd_if.cmd_data !== 38'h33) begin failures++; $display("FAIL rmq_rearm_data: got %h expected 33", cmd_if.cmd_data); end
        step(1'b1, 1'b0);
        checks++;
        if (fifo_level !== '0) begin failures++; $display("FAIL rmq_final_level: got %0d expected 0", fifo_level); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cycle     = 0;
        model_ovf = 1'b0;
        cmd_if.cmd_ready = 1'b0;
        test_reset();
        test_single_dr();
        test_backpressure();
        test_full_push_pop();
        test_simultaneous();
        test_random();
        test_reset_mid_queue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
